// File: rtl/adc_scan_ctrl.sv
// adc_scan_ctrl: mux-scanning sequencer for an 8-bit SAR ADC with an eoc synchroniser and a timeout.
// Define ADC_SCAN_AVG_EN to average four back-to-back conversions per channel.
module adc_scan_ctrl #(
  parameter int NUM_CH      = 4,
  parameter int CH_W        = 2,
  parameter int SETTLE_CYC  = 16,
  parameter int TIMEOUT_CYC = 1023
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              adc_sc,
  input  logic              adc_eoc,
  input  logic [7:0]        adc_resultado,
  output logic [CH_W-1:0]   mux_sel,
  output logic              busy,
  output logic              data_valid,
  output logic [CH_W-1:0]   data_ch,
  output logic [7:0]        data_out,
  output logic              scan_done,
  output logic              timeout_err
);

  localparam int CNT_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SETTLE  = 3'd1,
    SC_HI   = 3'd2,
    CONV    = 3'd3,
    CAPTURE = 3'd4,
    NEXT    = 3'd5
  } state_e;

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] mask_q, mask_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [1:0]        eoc_sync_q, eoc_sync_d;
  logic              adc_sc_q, adc_sc_d;
  logic [CH_W-1:0]   mux_sel_q, mux_sel_d;
  logic              busy_q, busy_d;
  logic              data_valid_q, data_valid_d;
  logic [CH_W-1:0]   data_ch_q, data_ch_d;
  logic [7:0]        data_out_q, data_out_d;
  logic              scan_done_q, scan_done_d;
  logic              timeout_err_q, timeout_err_d;
  logic              eoc_s;
  logic              abort_s;
  logic [CH_W:0]     first_s;
  logic [CH_W:0]     next_s;
`ifdef ADC_SCAN_AVG_EN
  logic [1:0]        rep_q, rep_d;
  logic [9:0]        acc_q, acc_d;
  logic [9:0]        sum_s;
`endif

  // Lowest set mask bit at or above lo; MSB of the result flags a hit.
  function automatic logic [CH_W:0] find_from(input logic [NUM_CH-1:0] mask, input int lo);
    logic [CH_W:0] hit;
    hit = {1'b0, {CH_W{1'b0}}};
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if ((i >= lo) && mask[i]) begin
        hit = {1'b1, CH_W'(i)};
      end
    end
    return hit;
  endfunction

  assign eoc_s   = eoc_sync_q[1];
  assign first_s = find_from(ch_mask, 0);
  assign next_s  = find_from(mask_q, int'(mux_sel_q) + 1);
`ifdef ADC_SCAN_AVG_EN
  assign sum_s   = acc_q + {2'b00, adc_resultado};
`endif

  // Next-state and registered-output logic for the scan FSM.
  always_comb begin
    state_d       = state_q;
    mask_d        = mask_q;
    cnt_d         = cnt_q;
    eoc_sync_d    = {eoc_sync_q[0], adc_eoc};
    adc_sc_d      = adc_sc_q;
    mux_sel_d     = mux_sel_q;
    data_valid_d  = 1'b0;
    data_ch_d     = data_ch_q;
    data_out_d    = data_out_q;
    scan_done_d   = 1'b0;
    timeout_err_d = timeout_err_q;
    abort_s       = 1'b0;
`ifdef ADC_SCAN_AVG_EN
    rep_d         = rep_q;
    acc_d         = acc_q;
`endif
    case (state_q)
      IDLE: begin
        adc_sc_d = 1'b0;
        if (start && (ch_mask != {NUM_CH{1'b0}})) begin
          mask_d        = ch_mask;
          timeout_err_d = 1'b0;
          mux_sel_d     = first_s[CH_W-1:0];
          cnt_d         = {CNT_W{1'b0}};
          state_d       = SETTLE;
`ifdef ADC_SCAN_AVG_EN
          rep_d         = 2'd0;
          acc_d         = 10'd0;
`endif
        end else begin
          state_d = IDLE;
        end
      end
      SETTLE: begin
        if (cnt_q == CNT_W'(SETTLE_CYC - 1)) begin
          adc_sc_d = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = SC_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      SC_HI: begin
        if (!eoc_s) begin
          adc_sc_d = 1'b0;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = CONV;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          abort_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CONV: begin
        if (eoc_s) begin
          state_d = CAPTURE;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYC - 1)) begin
          abort_s = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      CAPTURE: begin
`ifdef ADC_SCAN_AVG_EN
        // Repeats skip SETTLE: the mux has not moved since the first conversion.
        if (rep_q != 2'd3) begin
          acc_d    = sum_s;
          rep_d    = rep_q + 2'd1;
          adc_sc_d = 1'b1;
          cnt_d    = {CNT_W{1'b0}};
          state_d  = SC_HI;
        end else begin
          data_out_d   = sum_s[9:2];
          data_ch_d    = mux_sel_q;
          data_valid_d = 1'b1;
          scan_done_d  = ~next_s[CH_W];
          acc_d        = 10'd0;
          rep_d        = 2'd0;
          state_d      = NEXT;
        end
`else
        data_out_d   = adc_resultado;
        data_ch_d    = mux_sel_q;
        data_valid_d = 1'b1;
        scan_done_d  = ~next_s[CH_W];
        state_d      = NEXT;
`endif
      end
      NEXT: begin
        if (next_s[CH_W]) begin
          mux_sel_d = next_s[CH_W-1:0];
          cnt_d     = {CNT_W{1'b0}};
          state_d   = SETTLE;
        end else if (continuous && (ch_mask != {NUM_CH{1'b0}})) begin
          mask_d    = ch_mask;
          mux_sel_d = first_s[CH_W-1:0];
          cnt_d     = {CNT_W{1'b0}};
          state_d   = SETTLE;
        end else begin
          state_d = IDLE;
        end
      end
      default: begin
        adc_sc_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
    if (abort_s) begin
      adc_sc_d      = 1'b0;
      timeout_err_d = 1'b1;
      state_d       = IDLE;
`ifdef ADC_SCAN_AVG_EN
      rep_d         = 2'd0;
      acc_d         = 10'd0;
`endif
    end else begin
      timeout_err_d = timeout_err_d;
    end
    busy_d = (state_d != IDLE);
  end

  // State, synchroniser and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= IDLE;
      mask_q        <= {NUM_CH{1'b0}};
      cnt_q         <= {CNT_W{1'b0}};
      eoc_sync_q    <= 2'b11;
      adc_sc_q      <= 1'b0;
      mux_sel_q     <= {CH_W{1'b0}};
      busy_q        <= 1'b0;
      data_valid_q  <= 1'b0;
      data_ch_q     <= {CH_W{1'b0}};
      data_out_q    <= 8'd0;
      scan_done_q   <= 1'b0;
      timeout_err_q <= 1'b0;
`ifdef ADC_SCAN_AVG_EN
      rep_q         <= 2'd0;
      acc_q         <= 10'd0;
`endif
    end else begin
      state_q       <= state_d;
      mask_q        <= mask_d;
      cnt_q         <= cnt_d;
      eoc_sync_q    <= eoc_sync_d;
      adc_sc_q      <= adc_sc_d;
      mux_sel_q     <= mux_sel_d;
      busy_q        <= busy_d;
      data_valid_q  <= data_valid_d;
      data_ch_q     <= data_ch_d;
      data_out_q    <= data_out_d;
      scan_done_q   <= scan_done_d;
      timeout_err_q <= timeout_err_d;
`ifdef ADC_SCAN_AVG_EN
      rep_q         <= rep_d;
      acc_q         <= acc_d;
`endif
    end
  end

  assign adc_sc      = adc_sc_q;
  assign mux_sel     = mux_sel_q;
  assign busy        = busy_q;
  assign data_valid  = data_valid_q;
  assign data_ch     = data_ch_q;
  assign data_out    = data_out_q;
  assign scan_done   = scan_done_q;
  assign timeout_err = timeout_err_q;

endmodule

// File: tb/tb_adc_scan_ctrl.sv
// Scoreboard bench for adc_scan_ctrl with a behavioural SAR ADC on its own clock.
module tb_adc_scan_ctrl;

  logic       clk = 1'b0;
  logic       adc_clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       continuous = 1'b0;
  logic [3:0] ch_mask = 4'b0000;
  logic       adc_sc;
  logic       adc_eoc = 1'b1;
  logic [7:0] adc_resultado = 8'h00;
  logic [1:0] mux_sel;
  logic       busy;
  logic       data_valid;
  logic [1:0] data_ch;
  logic [7:0] data_out;
  logic       scan_done;
  logic       timeout_err;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [11:0] exp_q[$];
  logic [3:0]  mask_exp = 4'b0000;
  int          dv_cnt = 0;
  int          sd_cnt = 0;
  int          bad_mux = 0;

  logic [7:0]  adc_val [4];
  logic [7:0]  adc_step = 8'd0;
  logic        adc_stuck = 1'b0;
  int          conv_cnt = 0;
  int          conv_base = 0;
  logic        m_busy = 1'b0;
  logic [3:0]  m_cnt = 4'd0;
  logic [1:0]  m_ch = 2'd0;

  adc_scan_ctrl #(.NUM_CH(4), .CH_W(2), .SETTLE_CYC(16), .TIMEOUT_CYC(1023)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .continuous(continuous), .ch_mask(ch_mask),
    .adc_sc(adc_sc), .adc_eoc(adc_eoc), .adc_resultado(adc_resultado), .mux_sel(mux_sel),
    .busy(busy), .data_valid(data_valid), .data_ch(data_ch), .data_out(data_out),
    .scan_done(scan_done), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;
  always #7 adc_clk = ~adc_clk;

  // Behavioural ADC: eoc drops when sc is seen, result appears 10 ADC clocks later.
  always @(posedge adc_clk) begin
    if (!m_busy) begin
      if (adc_sc && !adc_stuck) begin
        m_busy  <= 1'b1;
        adc_eoc <= 1'b0;
        m_cnt   <= 4'd0;
        m_ch    <= mux_sel;
      end
    end else if (m_cnt == 4'd9) begin
      adc_resultado <= adc_val[m_ch] + 8'(adc_step * (conv_cnt - conv_base));
      conv_cnt      <= conv_cnt + 1;
      adc_eoc       <= 1'b1;
      m_busy        <= 1'b0;
    end else begin
      m_cnt <= m_cnt + 4'd1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    if (obs !== exp_v) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  function automatic logic [7:0] exp_val(input logic [7:0] v, input logic [7:0] step);
`ifdef ADC_SCAN_AVG_EN
    logic [9:0] s;
    s = 10'(4 * int'(v)) + 10'(6 * int'(step));
    return s[9:2];
`else
    return v;
`endif
  endfunction

  // Output monitor: pops the scoreboard on every data_valid.
  always @(negedge clk) begin
    if (rst_n && data_valid) begin
      dv_cnt++;
      if (exp_q.size() == 0) begin
        check_eq("dv_unexpected", 32'd1, 32'd0);
      end else begin
        logic [11:0] e;
        e = exp_q.pop_front();
        check_eq("data_ch", {30'd0, data_ch}, {28'd0, e[11:8]});
        check_eq("data_out", {24'd0, data_out}, {24'd0, e[7:0]});
      end
    end
    if (rst_n && scan_done) begin
      sd_cnt++;
      check_eq("sd_with_dv", {31'd0, data_valid}, 32'd1);
    end
    if (rst_n && busy && !mask_exp[mux_sel]) bad_mux++;
  end

  task automatic tick(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  task automatic pulse_start(input logic [3:0] m);
    ch_mask = m;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, input string tag);
    int i;
    i = 0;
    while (busy && i < max_cyc) begin
      @(negedge clk);
      i++;
    end
    check_eq(tag, {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int dv0, sd0, n;
    for (int c = 0; c < 4; c++) adc_val[c] = 8'd0;

    #1;
    check_eq("reset_outs", {15'd0, adc_sc, mux_sel, busy, data_valid, data_ch, data_out, scan_done, timeout_err}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(2);

    // Single channel 2
    adc_val[2] = 8'hA5;
    mask_exp = 4'b0100;
    dv0 = dv_cnt; sd0 = sd_cnt;
    exp_q.push_back({4'd2, exp_val(8'hA5, 8'd0)});
    pulse_start(4'b0100);
    check_eq("t1_mux_sel", {30'd0, mux_sel}, 32'd2);
    check_eq("t1_busy", {31'd0, busy}, 32'd1);
    n = 0;
    while (!adc_sc && n < 50) begin @(negedge clk); n++; end
    check_eq("t1_sc_rise", {31'd0, adc_sc}, 32'd1);
    n = 0;
    while (adc_sc && n < 100) begin @(negedge clk); n++; end
    check_eq("t1_sc_fall", {31'd0, adc_sc}, 32'd0);
    check_eq("t1_eoc_low_at_sc_fall", {31'd0, adc_eoc}, 32'd0);
    wait_idle(1000, "t1_idle");
    check_eq("t1_dv_count", dv_cnt - dv0, 32'd1);
    check_eq("t1_sd_count", sd_cnt - sd0, 32'd1);

    // Mask 1011, values 10+ch, mask changed mid-scan
    for (int c = 0; c < 4; c++) adc_val[c] = 8'(10 + c);
    mask_exp = 4'b1011;
    bad_mux = 0;
    dv0 = dv_cnt; sd0 = sd_cnt;
    exp_q.push_back({4'd0, exp_val(8'd10, 8'd0)});
    exp_q.push_back({4'd1, exp_val(8'd11, 8'd0)});
    exp_q.push_back({4'd3, exp_val(8'd13, 8'd0)});
    pulse_start(4'b1011);
    tick(5);
    ch_mask = 4'b0100;
    wait_idle(2000, "t2_idle");
    check_eq("t2_dv_count", dv_cnt - dv0, 32'd3);
    check_eq("t2_sd_count", sd_cnt - sd0, 32'd1);
    check_eq("t2_mux_never_2", bad_mux, 32'd0);
    check_eq("t2_queue_empty", exp_q.size(), 32'd0);

    // Stuck ADC: timeout in SC_HI
    adc_stuck = 1'b1;
    mask_exp = 4'b0001;
    dv0 = dv_cnt;
    pulse_start(4'b0001);
    n = 1;
    while (n < 500) begin @(negedge clk); n++; end
    check_eq("t3_sc_held", {31'd0, adc_sc}, 32'd1);
    check_eq("t3_no_early_timeout", {31'd0, timeout_err}, 32'd0);
    while (!timeout_err && n < 1200) begin @(negedge clk); n++; end
    check_eq("t3_timeout_set", {31'd0, timeout_err}, 32'd1);
    check_eq("t3_timeout_latency", {31'd0, (n >= 1030 && n <= 1050)}, 32'd1);
    check_eq("t3_sc_low", {31'd0, adc_sc}, 32'd0);
    check_eq("t3_idle", {31'd0, busy}, 32'd0);
    tick(10);
    check_eq("t3_sticky", {31'd0, timeout_err}, 32'd1);
    check_eq("t3_no_dv", dv_cnt - dv0, 32'd0);
    pulse_start(4'b0000);
    tick(5);
    check_eq("t3_zero_mask_ignored", {31'd0, busy}, 32'd0);
    check_eq("t3_zero_mask_keeps_err", {31'd0, timeout_err}, 32'd1);
    adc_stuck = 1'b0;
    adc_val[0] = 8'h5A;
    exp_q.push_back({4'd0, exp_val(8'h5A, 8'd0)});
    pulse_start(4'b0001);
    check_eq("t3_start_clears_err", {31'd0, timeout_err}, 32'd0);
    wait_idle(1000, "t3_idle2");

    // Continuous mode on ch0, cleared during the third scan
    adc_val[0] = 8'h33;
    dv0 = dv_cnt; sd0 = sd_cnt;
    for (int k = 0; k < 3; k++) exp_q.push_back({4'd0, exp_val(8'h33, 8'd0)});
    continuous = 1'b1;
    pulse_start(4'b0001);
    n = 0;
    while ((dv_cnt - dv0) < 2 && n < 2000) begin @(negedge clk); n++; end
    check_eq("t4_two_scans", dv_cnt - dv0, 32'd2);
    tick(20);
    continuous = 1'b0;
    wait_idle(2000, "t4_idle");
    check_eq("t4_dv_count", dv_cnt - dv0, 32'd3);
    check_eq("t4_sd_count", sd_cnt - sd0, 32'd3);
    check_eq("t4_queue_empty", exp_q.size(), 32'd0);

    // Asynchronous reset during CONV
    dv0 = dv_cnt; sd0 = sd_cnt;
    pulse_start(4'b0001);
    n = 0;
    while (!(busy && !adc_sc && !adc_eoc) && n < 200) begin @(negedge clk); n++; end
    check_eq("t5_in_conv", {31'd0, (busy && !adc_sc && !adc_eoc)}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check_eq("t5_reset_outs", {29'd0, adc_sc, busy, timeout_err}, 32'd0);
    tick(3);
    rst_n = 1'b1;
    tick(40);
    check_eq("t5_eoc_ignored", {31'd0, busy}, 32'd0);
    check_eq("t5_no_strobes", (dv_cnt - dv0) + (sd_cnt - sd0), 32'd0);
    pulse_start(4'b0000);
    tick(5);
    check_eq("t5_zero_mask_idle", {31'd0, busy}, 32'd0);

    // Ramp 100,101,102,103 on ch1
    adc_val[1] = 8'd100;
    adc_step = 8'd1;
    conv_base = conv_cnt;
    mask_exp = 4'b0010;
    dv0 = dv_cnt;
    exp_q.push_back({4'd1, exp_val(8'd100, 8'd1)});
    pulse_start(4'b0010);
    wait_idle(2000, "t6_idle");
    check_eq("t6_dv_count", dv_cnt - dv0, 32'd1);
    check_eq("t6_queue_empty", exp_q.size(), 32'd0);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
